// File: rtl/weight_tile_loader_if.sv
// weight_tile_loader_if
//   Bundles the tile-request, weight-memory read and FIFO push signals of the
//   weight tile loader.
//   slave  : the loader itself (drives memory strobes, FIFO push, status)
//   master : the surrounding system (issues start, returns memory data,
//            consumes the pushed rows)
//   Signals:
//     start, base_addr, num_rows    tile request (sampled with start)
//     mem_rd_en, mem_addr           weight memory read strobe / address
//     mem_rd_data                   memory read data, one cycle after mem_rd_en
//     weight_out, fifo_en           row and per-lane push enable to the FIFO
//     busy, done                    tile in progress / one-cycle completion
interface weight_tile_loader_if #(
  parameter int FIFO_INPUTS = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                              start;
  logic [ADDR_WIDTH-1:0]             base_addr;
  logic [CW-1:0]                     num_rows;
  logic                              mem_rd_en;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [FIFO_INPUTS*DATA_WIDTH-1:0] mem_rd_data;
  logic [FIFO_INPUTS*DATA_WIDTH-1:0] weight_out;
  logic [FIFO_INPUTS-1:0]            fifo_en;
  logic                              busy;
  logic                              done;

  modport slave (
    input  start, base_addr, num_rows, mem_rd_data,
    output mem_rd_en, mem_addr, weight_out, fifo_en, busy, done
  );

  modport master (
    output start, base_addr, num_rows, mem_rd_data,
    input  mem_rd_en, mem_addr, weight_out, fifo_en, busy, done
  );
endinterface

// File: rtl/weight_tile_loader.sv
// weight_tile_loader
//   Reads one tile of FIFO_DEPTH weight rows from a synchronous (1-cycle
//   latency) weight memory and pushes every row into the weight FIFO with an
//   all-lanes enable. Rows at or beyond the requested row count are pushed as
//   zeros, so each tile always produces exactly FIFO_DEPTH pushes.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset; abandons any tile in flight
//     bus    weight_tile_loader_if.slave (request, memory read, FIFO push,
//            busy/done status)
//   Timing: start sampled in cycle 0, rows issued in cycles 1..FIFO_DEPTH,
//   pushes in cycles 2..FIFO_DEPTH+1, done in cycle FIFO_DEPTH+2 (a start in
//   the done cycle is accepted).
module weight_tile_loader #(
  parameter int FIFO_INPUTS = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  weight_tile_loader_if.slave  bus
);

  localparam int              CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   LAST_K = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  // Saturate the requested row count to one full tile.
  function automatic logic [CW-1:0] clamp_rows(input logic [CW-1:0] n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         nrows_q, nrows_d;
  logic [CW-1:0]         k_q, k_d;
  logic [CW-1:0]         k_inc;
  logic [CW-1:0]         nrows_clamped;
  logic                  rd_en_p0, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_p0, addr_d;
  logic                  vld_p1, vld_d;
  logic                  real_p1, real_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  assign k_inc         = k_q + 1'b1;
  assign nrows_clamped = clamp_rows(bus.num_rows);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    nrows_d = nrows_q;
    k_d     = k_q;
    rd_en_d = 1'b0;
    addr_d  = '0;
    vld_d   = 1'b0;
    real_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          nrows_d = nrows_clamped;
          k_d     = '0;
          // Row 0 is presented to memory in the first READ cycle.
          addr_d  = bus.base_addr;
          rd_en_d = (nrows_clamped != '0);
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        // Row k is on the memory port this cycle; its push follows next cycle.
        vld_d  = 1'b1;
        real_d = rd_en_p0;
        if (k_q == LAST_K) begin
          state_d = FLUSH;
        end else begin
          k_d     = k_inc;
          addr_d  = base_q + ADDR_WIDTH'(k_inc);
          rd_en_d = (k_inc < nrows_q);
        end
      end
      FLUSH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: memory request; stage p1: FIFO push of the row read at p0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      nrows_q  <= '0;
      k_q      <= '0;
      rd_en_p0 <= 1'b0;
      addr_p0  <= '0;
      vld_p1   <= 1'b0;
      real_p1  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      nrows_q  <= nrows_d;
      k_q      <= k_d;
      rd_en_p0 <= rd_en_d;
      addr_p0  <= addr_d;
      vld_p1   <= vld_d;
      real_p1  <= real_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.mem_rd_en  = rd_en_p0;
  assign bus.mem_addr   = addr_p0;
  assign bus.fifo_en    = {FIFO_INPUTS{vld_p1}};
  // Padding rows and idle cycles present zeros; memory data passes only for
  // real rows in a push cycle.
  assign bus.weight_out = (vld_p1 && real_p1) ? bus.mem_rd_data : '0;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_weight_tile_loader.sv
module tb_weight_tile_loader;
  localparam int D  = 16;
  localparam int NC = D + 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [127:0] mem [256];

  logic [127:0] o_w    [0:NC];
  logic [15:0]  o_fen  [0:NC];
  logic         o_rd   [0:NC];
  logic [7:0]   o_addr [0:NC];
  logic         o_busy [0:NC];
  logic         o_done [0:NC];

  weight_tile_loader_if #(.FIFO_INPUTS(16), .DATA_WIDTH(8), .FIFO_DEPTH(D), .ADDR_WIDTH(8)) ifc ();

  weight_tile_loader #(.FIFO_INPUTS(16), .DATA_WIDTH(8), .FIFO_DEPTH(D), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: 1-cycle latency; junk on the bus when not reading.
  always @(posedge clk)
    ifc.mem_rd_data <= ifc.mem_rd_en ? mem[ifc.mem_addr]
                                     : {$urandom, $urandom, $urandom, $urandom};

  // Reference: pushed row i of a tile is the memory row at base+i (wrapping)
  // if i is below the clamped row count, else zero.
  function automatic int clampn(input logic [4:0] n);
    return (n > 5'd16) ? 16 : int'(n);
  endfunction

  function automatic logic [127:0] exp_row(input logic [7:0] base, input logic [4:0] n, input int i);
    if (i < clampn(n)) return mem[8'(int'(base) + i)];
    return '0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Issue a tile request in the current cycle (cycle 0) and record cycles
  // 1..NC. An optional extra start pulse is driven in cycle 'poke'.
  task automatic run_tile(input logic [7:0] base, input logic [4:0] n, input int poke);
    ifc.start     = 1'b1;
    ifc.base_addr = base;
    ifc.num_rows  = n;
    for (int c = 1; c <= NC; c++) begin
      @(posedge clk); #1;
      ifc.start = (c == poke);
      if (c == poke) begin
        ifc.base_addr = ~base;
        ifc.num_rows  = 5'd3;
      end
      o_w[c]    = ifc.weight_out;
      o_fen[c]  = ifc.fifo_en;
      o_rd[c]   = ifc.mem_rd_en;
      o_addr[c] = ifc.mem_addr;
      o_busy[c] = ifc.busy;
      o_done[c] = ifc.done;
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    total += 6;
    if (ifc.mem_rd_en !== 1'b0)     begin bad++; $display("FAIL reset_rd_en got=%b exp=0", ifc.mem_rd_en); end
    if (ifc.mem_addr !== 8'h0)      begin bad++; $display("FAIL reset_addr got=%h exp=00", ifc.mem_addr); end
    if (ifc.fifo_en !== 16'h0)      begin bad++; $display("FAIL reset_fifo_en got=%h exp=0000", ifc.fifo_en); end
    if (ifc.weight_out !== 128'h0)  begin bad++; $display("FAIL reset_weight got=%h exp=0", ifc.weight_out); end
    if (ifc.busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    if (ifc.done !== 1'b0)          begin bad++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (ifc.fifo_en !== 16'h0 || ifc.busy !== 1'b0) begin
        bad++; $display("FAIL idle_no_push c=%0d fifo_en=%h busy=%b exp=0", c, ifc.fifo_en, ifc.busy);
      end
    end
  endtask

  task automatic test_full_tile();
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i + 1);
      mem[i] = {16{b}};
    end
    run_tile(8'h00, 5'd16, 0);
    for (int c = 1; c <= NC; c++) begin
      b = 8'(c - 1);
      total += 3;
      if (o_fen[c] !== ((c >= 2 && c <= D + 1) ? 16'hFFFF : 16'h0)) begin
        bad++; $display("FAIL full_fifo_en c=%0d got=%h", c, o_fen[c]);
      end
      if (o_w[c] !== ((c >= 2 && c <= D + 1) ? {16{b}} : 128'h0)) begin
        bad++; $display("FAIL full_row c=%0d got=%h exp=%h", c, o_w[c], {16{b}});
      end
      if (o_done[c] !== (c == NC)) begin
        bad++; $display("FAIL full_done c=%0d got=%b exp=%b", c, o_done[c], c == NC);
      end
    end
  endtask

  task automatic test_partial();
    logic [7:0] base;
    int pushes;
    fill_random();
    base = 8'($urandom_range(0, 255));
    run_tile(base, 5'd5, 0);
    pushes = 0;
    for (int c = 1; c <= NC; c++) begin
      if (o_fen[c] === 16'hFFFF) pushes++;
      total++;
      if (o_rd[c] !== (c <= 5)) begin
        bad++; $display("FAIL partial_rd_en c=%0d got=%b exp=%b", c, o_rd[c], c <= 5);
      end
      if (c >= 2 && c <= D + 1) begin
        total++;
        if (o_w[c] !== exp_row(base, 5'd5, c - 2)) begin
          bad++; $display("FAIL partial_row c=%0d got=%h exp=%h", c, o_w[c], exp_row(base, 5'd5, c - 2));
        end
      end
    end
    total++;
    if (pushes !== 16) begin bad++; $display("FAIL partial_pushes got=%0d exp=16", pushes); end
  endtask

  task automatic test_wrap();
    fill_random();
    run_tile(8'hF8, 5'd16, 0);
    for (int c = 1; c <= D; c++) begin
      total += 2;
      if (o_addr[c] !== 8'(8'hF8 + c - 1)) begin
        bad++; $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, o_addr[c], 8'(8'hF8 + c - 1));
      end
      if (o_w[c + 1] !== exp_row(8'hF8, 5'd16, c - 1)) begin
        bad++; $display("FAIL wrap_row c=%0d got=%h exp=%h", c + 1, o_w[c + 1], exp_row(8'hF8, 5'd16, c - 1));
      end
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    run_tile(8'h40, 5'd16, 7);
    for (int c = 2; c <= D + 1; c++) begin
      total++;
      if (o_w[c] !== exp_row(8'h40, 5'd16, c - 2)) begin
        bad++; $display("FAIL ignored_row c=%0d got=%h exp=%h", c, o_w[c], exp_row(8'h40, 5'd16, c - 2));
      end
    end
    total++;
    if (o_done[NC] !== 1'b1) begin bad++; $display("FAIL ignored_done got=%b exp=1", o_done[NC]); end
    @(posedge clk); #1;
    total++;
    if (ifc.busy !== 1'b0 || ifc.mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL ignored_queued busy=%b rd_en=%b exp=0", ifc.busy, ifc.mem_rd_en);
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_tile(8'h10, 5'd20, 0);
    for (int c = 2; c <= D + 1; c++) begin
      total++;
      if (o_w[c] !== mem[8'(8'h10 + c - 2)]) begin
        bad++; $display("FAIL clamp_row c=%0d got=%h exp=%h", c, o_w[c], mem[8'(8'h10 + c - 2)]);
      end
    end
    total++;
    if (o_done[NC] !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", o_done[NC]); end
    // Second request issued in the done cycle of the first.
    run_tile(8'hA0, 5'd7, 0);
    total += 3;
    if (o_fen[1] !== 16'h0)    begin bad++; $display("FAIL b2b_c1_fifo_en got=%h exp=0000", o_fen[1]); end
    if (o_fen[2] !== 16'hFFFF) begin bad++; $display("FAIL b2b_c2_fifo_en got=%h exp=ffff", o_fen[2]); end
    if (o_busy[1] !== 1'b1)    begin bad++; $display("FAIL b2b_busy got=%b exp=1", o_busy[1]); end
    for (int c = 2; c <= D + 1; c++) begin
      total++;
      if (o_w[c] !== exp_row(8'hA0, 5'd7, c - 2)) begin
        bad++; $display("FAIL b2b_row c=%0d got=%h exp=%h", c, o_w[c], exp_row(8'hA0, 5'd7, c - 2));
      end
    end
  endtask

  task automatic test_mid_reset();
    int pushes;
    int dones;
    fill_random();
    ifc.start = 1'b1; ifc.base_addr = 8'h22; ifc.num_rows = 5'd16;
    pushes = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      ifc.start = 1'b0;
      if (ifc.fifo_en === 16'hFFFF) pushes++;
    end
    total++;
    if (pushes !== 8) begin bad++; $display("FAIL midrst_pushes got=%0d exp=8", pushes); end
    #2 reset = 1'b1;
    #1;
    total += 3;
    if (ifc.fifo_en !== 16'h0)     begin bad++; $display("FAIL midrst_fifo_en got=%h exp=0000", ifc.fifo_en); end
    if (ifc.busy !== 1'b0)         begin bad++; $display("FAIL midrst_busy got=%b exp=0", ifc.busy); end
    if (ifc.weight_out !== 128'h0) begin bad++; $display("FAIL midrst_weight got=%h exp=0", ifc.weight_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    pushes = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ifc.fifo_en !== 16'h0) pushes++;
      if (ifc.done !== 1'b0) dones++;
    end
    total += 2;
    if (pushes !== 0) begin bad++; $display("FAIL midrst_late_push got=%0d exp=0", pushes); end
    if (dones !== 0)  begin bad++; $display("FAIL midrst_done got=%0d exp=0", dones); end
    run_tile(8'h30, 5'd9, 0);
    for (int c = 2; c <= D + 1; c++) begin
      total++;
      if (o_w[c] !== exp_row(8'h30, 5'd9, c - 2) || o_fen[c] !== 16'hFFFF) begin
        bad++; $display("FAIL midrst_reload c=%0d got=%h exp=%h", c, o_w[c], exp_row(8'h30, 5'd9, c - 2));
      end
    end
    total++;
    if (o_done[NC] !== 1'b1) begin bad++; $display("FAIL midrst_reload_done got=%b exp=1", o_done[NC]); end
  endtask

  task automatic test_random();
    logic [7:0] base;
    logic [4:0] n;
    int nc;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      base = 8'($urandom_range(0, 255));
      n    = (it == 0) ? 5'd0 : 5'($urandom_range(0, 20));
      nc   = clampn(n);
      run_tile(base, n, 0);
      for (int c = 1; c <= NC; c++) begin
        total += 4;
        if (o_fen[c] !== ((c >= 2 && c <= D + 1) ? 16'hFFFF : 16'h0)) begin
          bad++; $display("FAIL rnd_fifo_en it=%0d c=%0d got=%h", it, c, o_fen[c]);
        end
        if (o_w[c] !== ((c >= 2 && c <= D + 1) ? exp_row(base, n, c - 2) : 128'h0)) begin
          bad++; $display("FAIL rnd_row it=%0d c=%0d got=%h", it, c, o_w[c]);
        end
        if (o_rd[c] !== (c <= D && (c - 1) < nc)) begin
          bad++; $display("FAIL rnd_rd_en it=%0d c=%0d got=%b", it, c, o_rd[c]);
        end
        if (o_busy[c] !== (c <= D + 1) || o_done[c] !== (c == NC)) begin
          bad++; $display("FAIL rnd_status it=%0d c=%0d busy=%b done=%b", it, c, o_busy[c], o_done[c]);
        end
        if (c <= D) begin
          total++;
          if (o_addr[c] !== 8'(int'(base) + c - 1)) begin
            bad++; $display("FAIL rnd_addr it=%0d c=%0d got=%h exp=%h", it, c, o_addr[c], 8'(int'(base) + c - 1));
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ifc.start = 1'b0;
    ifc.base_addr = '0;
    ifc.num_rows = '0;
    fill_random();
    test_reset();
    test_full_tile();
    test_partial();
    test_wrap();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_tile_loader.md
# weight_tile_loader

Upstream feeder for the weight FIFO in the TPU weight path. On a start pulse it reads one weight tile of FIFO_DEPTH rows from the synchronous weight memory. It presents each row as a FIFO_INPUTS×DATA_WIDTH word together with an all-lanes push enable, so the weight FIFO fills completely before FIFO_Ctrl performs the staggered unload into the systolic array. Rows beyond the requested row count are pushed as zeros, so the FIFO always receives exactly FIFO_DEPTH pushes per tile.

## Interface
Parameters:
- FIFO_INPUTS, 16, lanes per row (one weight per lane)
- DATA_WIDTH, 8, bits per weight
- FIFO_DEPTH, 16, rows per tile (≥2)
- ADDR_WIDTH, 8, weight memory address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- base_addr  in  ADDR_WIDTH  address of tile row 0; sampled with start
- num_rows  in  $clog2(FIFO_DEPTH)+1  valid rows in the tile; sampled with start
- mem_rd_en  out  1  weight memory read strobe
- mem_addr  out  ADDR_WIDTH  weight memory read address
- mem_rd_data  in  FIFO_INPUTS*DATA_WIDTH  read data, valid the cycle after mem_rd_en
- weight_out  out  FIFO_INPUTS*DATA_WIDTH  row to the FIFO weightIn
- fifo_en  out  FIFO_INPUTS  per-lane push enable to the FIFO en
- busy  out  1  tile load in progress
- done  out  1  one-cycle pulse after the last push

## Operation
- FSM states: IDLE, READ, FLUSH.
- **IDLE:**
  - Sample start. When start=1:
    - Latch base_addr.
    - Latch num_rows, clamped to FIFO_DEPTH.
    - Clear the row counter k.
    - Go to READ.
  - start outside IDLE is ignored. It is neither queued nor an error.
- **READ:** one row per cycle, k = 0..FIFO_DEPTH-1.
  - mem_addr = base_addr + k, modulo 2^ADDR_WIDTH (wraps, no error).
  - mem_rd_en = 1 only when k < num_rows_latched. Otherwise no memory access.
  - A valid bit and a "row is real" bit for row k enter a 1-stage pipeline.
  - When k = FIFO_DEPTH-1, go to FLUSH.
- **FLUSH:**
  - One cycle that drains the last pipeline stage.
  - Then go to IDLE and pulse done.
- **Push stage (cycle after row k issued):**
  - fifo_en = all ones.
  - weight_out = mem_rd_data for a real row, else all zeros.
  - Outside push cycles: fifo_en = 0 and weight_out = 0.
- **num_rows = 0:** FIFO_DEPTH zero rows are pushed and mem_rd_en never asserts. This clears the FIFO contents.
- **Registers vs. combinational:**
  - fifo_en, the zero-select, mem_addr, mem_rd_en, busy and done are registered.
  - weight_out is a combinational mux on mem_rd_data.
- **Reset:**
  - Asynchronous. Forces IDLE and clears all registers and the pipeline.
  - Outputs go to 0 immediately: mem_rd_en, mem_addr, fifo_en, weight_out, busy, done.
  - Reset mid-tile abandons the tile and performs no further pushes. The FIFO holds a partial tile; the owner resets the FIFO too.

## Timing
- Cycle numbering: start sampled at the edge ending cycle 0.
- Cycles 1..FIFO_DEPTH: READ, with row k issued in cycle k+1.
- Cycles 2..FIFO_DEPTH+1: fifo_en high, one push per cycle.
- Cycle FIFO_DEPTH+1: FLUSH.
- Cycle FIFO_DEPTH+2: done=1, busy=0, state IDLE. A start in this same cycle is accepted, so back-to-back tiles have period FIFO_DEPTH+2.
- busy = 1 for cycles 1..FIFO_DEPTH+1.
- Start-to-done latency = FIFO_DEPTH+2 cycles (18 at defaults).
- Memory contract: 1-cycle read latency, no stalls. There is no backpressure input. The controller issues start only while FIFO_Ctrl is not unloading.

## Test plan
- **Reset values:** assert reset at t=3ns, asynchronously.
  - Required: every output reads 0 before the next clock edge.
  - Required: after release, no fifo_en without start.
- **Full tile:** memory row i = {16{8'(i+1)}}; start with base_addr=0, num_rows=16.
  - Required: fifo_en=16'hFFFF in cycles 2..17, carrying rows 1..16 in order.
  - Required: done in cycle 18.
  - Required: the attached weightFIFO plus FIFO_Ctrl staggered unload reproduces those rows.
- **Partial tile:** num_rows=5.
  - Required: mem_rd_en high only in cycles 1..5.
  - Required: 16 pushes total; rows 6..16 all 128'h0.
- **Address wrap:** base_addr=8'hF8, num_rows=16.
  - Required: mem_addr sequence F8..FF, 00..07.
- **Ignored and back-to-back start:**
  - start pulsed in cycle 7: no effect.
  - start in the done cycle: a second tile begins; its first push lands exactly 2 cycles later.
  - num_rows=20: clamped, giving 16 real rows.
- **Mid-tile reset:** reset in cycle 9 (8 rows pushed).
  - Required: fifo_en drops immediately; busy=0; no done pulse.
  - Required: the next start loads normally.
